// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the instruction-cache refill block.
package icache_pkg;
    localparam int XLEN      = 64;
    localparam int LINES_DEF = 64;
    localparam int WORDS_DEF = 4;
    localparam int OFF_W     = $clog2(WORDS_DEF);
    localparam int IDX_W     = $clog2(LINES_DEF);
    localparam int TAG_W     = XLEN - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_FAULT
    } state_t;

    function automatic int tag_width(input int lines, input int words);
        return XLEN - $clog2(lines) - $clog2(words) - 2;
    endfunction
endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: async read, sync write, bulk valid clear.
module icache_array #(
    parameter int LINES = 64,
    parameter int WORDS = 4,
    parameter int TAG_W = 52
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     clear_all,
    input  logic                     inval,
    input  logic                     fill_wr,
    input  logic                     tag_wr,
    input  logic                     set_vld,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic [$clog2(WORDS)-1:0] wr_off,
    input  logic [31:0]              wr_data,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    input  logic [$clog2(WORDS)-1:0] rd_off,
    output logic [TAG_W-1:0]         rd_tag,
    output logic                     rd_valid,
    output logic [31:0]              rd_data
);
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][WORDS];
    logic [LINES-1:0] valid;

    always_ff @(posedge CLK) begin
        if (fill_wr) data[wr_idx][wr_off] <= wr_data;
        if (tag_wr)  tags[wr_idx]         <= wr_tag;
    end

    // Bulk clear wins over the per-line updates.
    always_ff @(posedge CLK) begin
        if (RESET || clear_all) valid <= '0;
        else if (inval)         valid[wr_idx] <= 1'b0;
        else if (set_vld)       valid[wr_idx] <= 1'b1;
    end

    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_data  = data[rd_idx][rd_off];
endmodule

// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a single outstanding line refill FSM.
module icache_refill
    import icache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] PC,
    input  logic        FLUSH,
    output logic        cache_hit,
    output logic [31:0] instruction,
    output logic        MEM_REQ,
    output logic [63:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ERR,
    output logic        FAULT
);
    localparam int O_W  = $clog2(WORDS);
    localparam int I_W  = $clog2(LINES);
    localparam int T_W  = tag_width(LINES, WORDS);
    localparam int LA_W = XLEN - O_W - 2;

    state_t          state;
    logic [O_W-1:0]  beat;
    logic            discard;
    logic [LA_W-1:0] miss_line;

    logic [LA_W-1:0] pc_line;
    logic [T_W-1:0]  rd_tag;
    logic            rd_valid, ack_ok, last_beat;
    logic            unused_pc;

    assign pc_line   = PC[XLEN-1:O_W+2];
    assign unused_pc = ^PC[1:0];

    // The faulting line is never reported as a hit, even if the PC lingers on it.
    assign cache_hit = rd_valid && (rd_tag == PC[XLEN-1 -: T_W])
                       && !(state == ST_FAULT && pc_line == miss_line);

    assign last_beat = (beat == O_W'(WORDS - 1));
    assign ack_ok    = (state == ST_REFILL) && MEM_ACK && !MEM_ERR && !RESET;

    icache_array #(.LINES(LINES), .WORDS(WORDS), .TAG_W(T_W)) u_array (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear_all (FLUSH),
        .inval     ((state == ST_IDLE) && !cache_hit && !FLUSH && !RESET),
        .fill_wr   (ack_ok),
        .tag_wr    (ack_ok && last_beat),
        .set_vld   (ack_ok && last_beat && !discard && !FLUSH),
        .wr_idx    ((state == ST_IDLE) ? PC[O_W+2 +: I_W] : miss_line[I_W-1:0]),
        .wr_off    (beat),
        .wr_data   (MEM_RDATA),
        .wr_tag    (miss_line[LA_W-1 -: T_W]),
        .rd_idx    (PC[O_W+2 +: I_W]),
        .rd_off    (PC[2 +: O_W]),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_data   (instruction)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            beat     <= '0;
            discard  <= 1'b0;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= '0;
            FAULT    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (!cache_hit && !FLUSH) begin
                    miss_line <= pc_line;
                    beat      <= '0;
                    discard   <= 1'b0;
                    MEM_REQ   <= 1'b1;
                    MEM_ADDR  <= {pc_line, {(O_W+2){1'b0}}};
                    state     <= ST_REFILL;
                end
                ST_REFILL: begin
                    if (FLUSH) discard <= 1'b1;
                    if (MEM_ACK) begin
                        if (MEM_ERR) begin
                            MEM_REQ <= 1'b0;
                            FAULT   <= 1'b1;
                            state   <= ST_FAULT;
                        end else if (last_beat) begin
                            MEM_REQ <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            beat     <= beat + 1'b1;
                            MEM_ADDR <= MEM_ADDR + 64'd4;
                        end
                    end
                end
                ST_FAULT: if (pc_line != miss_line || FLUSH) begin
                    FAULT <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
